uart_rx_byte: RTL and testbench
===============================

// Module: uart_rx_byte
// PURPOSE
//  UART receiver, 8N1, LSB first; downstream consumer of the transmitter's uart_txd line.
//  Deserialises one byte per frame and holds it in a one-byte output register until read.
//  Flags a bad stop bit (frame error) and a byte lost to an unread register (overrun).
//  Used on-board as the loopback checker and as the host-to-FPGA command input.
// PARAMETERS
//  CLKS_PER_BIT  5208  clk_50M cycles per bit: 50 MHz / 9600 baud (434 for 115200)
//  SYNC_STAGES   2     metastability flops on uart_rxd, minimum 2
// PORTS
//  clk_50M      in   1  system clock, 50 MHz, rising edge
//  reset        in   1  asynchronous, active-high; clears all state
//  uart_rxd     in   1  serial input; asynchronous to clk_50M; idles high
//  read         in   1  1-cycle pop strobe; consumes read_value and clears rx_ready and overrun
//  read_value   out  8  last received byte; valid while rx_ready=1
//  rx_ready     out  1  byte held, not yet read
//  overrun      out  1  sticky; a byte completed while rx_ready=1 and was dropped
//  frame_error  out  1  1-cycle pulse; stop bit sampled low
// BEHAVIOUR
//  Reset values: read_value=8'h00, rx_ready=0, overrun=0, frame_error=0, state=IDLE.
//  Sync chain resets to 1, so reset release on an idle line never produces a start.
//  rxd_s is uart_rxd after SYNC_STAGES flops. All sampling uses rxd_s.
//  bit_cnt counts 0..CLKS_PER_BIT-1; bit_idx is 3 bits.
//  FSM states:
//   IDLE    on rxd_s=0: bit_cnt<=0, go to START.
//   START   at bit_cnt=CLKS_PER_BIT/2-1, sample rxd_s (mid start bit):
//           if 0, bit_cnt<=0, bit_idx<=0, go to DATA; if 1 (glitch), go to IDLE with no output.
//   DATA    at bit_cnt=CLKS_PER_BIT-1, shift[bit_idx]<=rxd_s and bit_cnt<=0.
//           After bit_idx=7, go to STOP.
//   STOP    at bit_cnt=CLKS_PER_BIT-1, sample stop bit:
//           1 = deliver the byte and go to IDLE;
//           0 = pulse frame_error, discard the byte, go to BREAK.
//   BREAK   wait for rxd_s=1, then go to IDLE. A held-low line gives exactly one frame_error.
//  Leaving STOP at mid-stop-bit allows up to 1/2 bit of baud mismatch before the next start edge.
//  Deliver, in the cycle after the stop sample:
//   - if rx_ready=0 (or read=1 in that cycle): read_value<=shift, rx_ready<=1.
//   - otherwise: keep the old byte and set overrun<=1.
//  read while rx_ready=1: rx_ready<=0, overrun<=0 next cycle.
//  read while rx_ready=0: no effect.
//  read and deliver in the same cycle: the new byte is loaded, rx_ready stays 1, overrun<=0.
//  Latency: rx_ready rises 2 + SYNC_STAGES + (CLKS_PER_BIT/2) + 9*CLKS_PER_BIT cycles after
//   the uart_rxd falling edge (about 9.5 bit times).
//  Reset asserted mid-frame: immediate return to IDLE; the partial byte is lost, no flags.
//  After reset release mid-frame: any low data bit is taken as a start. That frame may
//   frame-error, and the receiver resynchronises at the next idle.
// STRUCTURE
//  Package uart_pkg:
//   - localparam CLKS_PER_BIT_9600=5208 and CLKS_PER_BIT_115200=434
//   - state enum {IDLE, START, DATA, STOP, BREAK}, 3 bits
//  Shared with the TX block.
//  Sub-module: uart_sync (SYNC_STAGES flop chain, reset value 1), reusable by any async input.
//  Remaining logic is one FSM plus the bit_cnt, bit_idx, shift and output registers in this file.
// TESTING
//  Loopback: transmitter uart_txd -> uart_rxd.
//   Bytes 8'h21, 8'h43, 8'h65 at 9600, each read after arrival.
//   -> read_value matches each byte, rx_ready 1 -> 0 on read, no flags.
//  Glitch: uart_rxd low for 1000 ns in idle.
//   -> FSM returns to IDLE, rx_ready stays 0, no frame_error.
//  Frame error: drive 8'hA5 with stop bit = 0, then line high.
//   -> one frame_error pulse, rx_ready stays 0.
//   Then send 8'h5A with a good frame -> 8'h5A received.
//  Overrun: send 8'h11 then 8'h22 with no read.
//   -> read_value=8'h11, overrun=1.
//   Then read -> rx_ready=0, overrun=0.
//  Read on the delivery cycle: assert read exactly at the cycle that completes 8'h33 while
//   8'h11 is held.
//   -> read_value=8'h33, rx_ready=1, overrun=0.
//  Reset mid-frame: assert reset during data bit 4 of 8'hFF, release, then send 8'h0F.
//   -> outputs at reset values, then 8'h0F received (a frame_error on the first frame is allowed).

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - baud divisors and receiver state encoding shared by the UART blocks
`timescale 1ns/1ps
package uart_pkg;

   localparam int CLKS_PER_BIT_9600   = 5208;
   localparam int CLKS_PER_BIT_115200 = 434;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - flop chain bringing an asynchronous input into the clk domain
`timescale 1ns/1ps
module uart_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // Resets high so an idle serial line never looks like a start edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) chain <= '1;
      else     chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART receiver with a one-byte holding register
`timescale 1ns/1ps
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk_50M,
   input  logic       reset,
   input  logic       uart_rxd,
   input  logic       read,
   output logic [7:0] read_value,
   output logic       rx_ready,
   output logic       overrun,
   output logic       frame_error
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

   logic             rxd_s;
   state_t           state;
   logic [CNT_W-1:0] bit_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;
   logic             deliver;

   uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk_50M),
      .rst (reset),
      .d   (uart_rxd),
      .q   (rxd_s)
   );

   always_ff @(posedge clk_50M or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         deliver     <= 1'b0;
         read_value  <= 8'h00;
         rx_ready    <= 1'b0;
         overrun     <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         deliver     <= 1'b0;
         frame_error <= 1'b0;

         case (state)
            IDLE: begin
               if (!rxd_s) begin
                  bit_cnt <= '0;
                  state   <= START;
               end
            end
            START: begin
               if (bit_cnt == HALF_LAST) begin
                  bit_cnt <= '0;
                  bit_idx <= '0;
                  state   <= rxd_s ? IDLE : DATA;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_cnt == BIT_LAST) begin
                  shift[bit_idx] <= rxd_s;
                  bit_cnt        <= '0;
                  bit_idx        <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) state <= STOP;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            // Leave at mid-stop so the next start edge is caught despite baud skew.
            STOP: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt <= '0;
                  if (rxd_s) begin
                     deliver <= 1'b1;
                     state   <= IDLE;
                  end else begin
                     frame_error <= 1'b1;
                     state       <= BREAK;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            BREAK: begin
               if (rxd_s) state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // A read in the delivery cycle frees the register for the new byte.
         if (deliver) begin
            if (!rx_ready || read) begin
               read_value <= shift;
               rx_ready   <= 1'b1;
               if (read) overrun <= 1'b0;
            end else begin
               overrun <= 1'b1;
            end
         end else if (read && rx_ready) begin
            rx_ready <= 1'b0;
            overrun  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb/tb_uart_rx_byte.sv - scoreboard bench for uart_rx_byte with a byte-level reference model
`timescale 1ns/1ps
module tb_uart_rx_byte;

   localparam int CPB  = 120;
   localparam int SYNC = 2;
   localparam int LAT  = 2 + SYNC + CPB / 2 + 9 * CPB;

   typedef enum {EV_BYTE, EV_OVR, EV_FERR} ev_kind_t;
   typedef struct {
      ev_kind_t   kind;
      logic [7:0] data;
   } ev_t;

   logic       clk_50M = 1'b0;
   logic       reset;
   logic       uart_rxd;
   logic       read;
   logic [7:0] read_value;
   logic       rx_ready;
   logic       overrun;
   logic       frame_error;

   int  checks   = 0;
   int  failures = 0;
   ev_t exp_q[$];

   logic       model_held = 1'b0;
   logic       model_ovr  = 1'b0;
   logic [7:0] model_val  = 8'h00;

   uart_rx_byte #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
      .clk_50M     (clk_50M),
      .reset       (reset),
      .uart_rxd    (uart_rxd),
      .read        (read),
      .read_value  (read_value),
      .rx_ready    (rx_ready),
      .overrun     (overrun),
      .frame_error (frame_error)
   );

   always #10 clk_50M = ~clk_50M;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_50M);
      #1;
   endtask

   task automatic push_ev(input ev_kind_t kind, input logic [7:0] data);
      ev_t e;
      e.kind = kind;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // Reference model: what a frame should cause, decided when the frame is issued.
   task automatic expect_frame(input logic [7:0] b, input logic stop_bit, input logic read_same);
      if (!stop_bit) begin
         push_ev(EV_FERR, 8'h00);
      end else if (!model_held || read_same) begin
         push_ev(EV_BYTE, b);
         model_held = 1'b1;
         model_val  = b;
         if (read_same) model_ovr = 1'b0;
      end else begin
         if (!model_ovr) push_ev(EV_OVR, 8'h00);
         model_ovr = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int rd_at,
                             input int tail_low, output int rise_at);
      logic [9:0] bits;
      logic [3:0] bi;
      logic       was_ready;
      bits      = {stop_bit, b, 1'b0};
      rise_at   = -1;
      was_ready = rx_ready;
      for (int cyc = 0; cyc < 10 * CPB; cyc++) begin
         if (rise_at < 0 && !was_ready && rx_ready) rise_at = cyc;
         bi       = 4'(cyc / CPB);
         uart_rxd = bits[bi];
         read     = (cyc == rd_at - 1);
         tick(1);
      end
      read = 1'b0;
      if (tail_low > 0) tick(tail_low);
      uart_rxd = 1'b1;
      tick(4);
   endtask

   task automatic do_read(input string tag);
      check({tag, " ready before read"}, 32'(rx_ready), 32'(model_held));
      check({tag, " overrun before read"}, 32'(overrun), 32'(model_ovr));
      if (model_held) check({tag, " read_value"}, 32'(read_value), 32'(model_val));
      read = 1'b1;
      tick(1);
      read       = 1'b0;
      model_held = 1'b0;
      model_ovr  = 1'b0;
      tick(1);
      check({tag, " ready after read"}, 32'(rx_ready), 32'd0);
      check({tag, " overrun after read"}, 32'(overrun), 32'd0);
   endtask

   task automatic check_event(input ev_kind_t kind, input logic [7:0] data);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL event: got %s %02h expected none", kind.name(), data);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || (kind == EV_BYTE && e.data != data)) begin
            failures++;
            $display("FAIL event: got %s %02h expected %s %02h", kind.name(), data,
                     e.kind.name(), e.data);
         end
      end
   endtask

   // Monitor: turns DUT output activity into events and matches them against the queue.
   initial begin : monitor
      logic p_rdy, p_read, p_ovr;
      p_rdy  = 1'b0;
      p_read = 1'b0;
      p_ovr  = 1'b0;
      forever begin
         @(negedge clk_50M);
         if (frame_error) check_event(EV_FERR, 8'h00);
         if (overrun && !p_ovr) check_event(EV_OVR, 8'h00);
         if (rx_ready && (!p_rdy || p_read)) check_event(EV_BYTE, read_value);
         p_rdy  = rx_ready;
         p_read = read;
         p_ovr  = overrun;
      end
   end

   initial begin : stimulus
      logic [7:0] lb [3];
      logic [7:0] b;
      logic       sb;
      int         rise;
      lb = '{8'h21, 8'h43, 8'h65};

      reset    = 1'b1;
      uart_rxd = 1'b1;
      read     = 1'b0;
      tick(3);
      check("reset read_value", 32'(read_value), 32'h00);
      check("reset rx_ready", 32'(rx_ready), 32'd0);
      check("reset overrun", 32'(overrun), 32'd0);
      check("reset frame_error", 32'(frame_error), 32'd0);
      reset = 1'b0;
      tick(5);

      for (int i = 0; i < 3; i++) begin
         expect_frame(lb[i], 1'b1, 1'b0);
         send_frame(lb[i], 1'b1, 0, 0, rise);
         if (i == 0) check("latency", 32'(rise), 32'(LAT));
         do_read("loopback");
      end

      uart_rxd = 1'b0;
      tick(50);
      uart_rxd = 1'b1;
      tick(2 * CPB);
      check("glitch rx_ready", 32'(rx_ready), 32'd0);

      expect_frame(8'hA5, 1'b0, 1'b0);
      send_frame(8'hA5, 1'b0, 0, 3 * CPB, rise);
      check("frame error rx_ready", 32'(rx_ready), 32'd0);
      expect_frame(8'h5A, 1'b1, 1'b0);
      send_frame(8'h5A, 1'b1, 0, 0, rise);
      do_read("after frame error");

      expect_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h11, 1'b1, 0, 0, rise);
      expect_frame(8'h22, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 0, 0, rise);
      do_read("overrun");

      expect_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h11, 1'b1, 0, 0, rise);
      expect_frame(8'h22, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 0, 0, rise);
      expect_frame(8'h33, 1'b1, 1'b1);
      send_frame(8'h33, 1'b1, LAT, 0, rise);
      check("read on delivery read_value", 32'(read_value), 32'h33);
      check("read on delivery rx_ready", 32'(rx_ready), 32'd1);
      check("read on delivery overrun", 32'(overrun), 32'd0);

      expect_frame(8'h44, 1'b1, 1'b0);
      send_frame(8'h44, 1'b1, 0, 0, rise);
      uart_rxd = 1'b0;
      tick(CPB);
      uart_rxd = 1'b1;
      tick(4 * CPB + CPB / 2);
      reset = 1'b1;
      tick(2);
      check("mid-frame reset read_value", 32'(read_value), 32'h00);
      check("mid-frame reset rx_ready", 32'(rx_ready), 32'd0);
      check("mid-frame reset overrun", 32'(overrun), 32'd0);
      check("mid-frame reset frame_error", 32'(frame_error), 32'd0);
      reset      = 1'b0;
      model_held = 1'b0;
      model_ovr  = 1'b0;
      tick(5 * CPB);
      expect_frame(8'h0F, 1'b1, 1'b0);
      send_frame(8'h0F, 1'b1, 0, 0, rise);
      do_read("after reset");

      for (int i = 0; i < 12; i++) begin
         b  = 8'($urandom);
         sb = ($urandom_range(0, 5) != 0);
         expect_frame(b, sb, 1'b0);
         send_frame(b, sb, 0, 0, rise);
         if ($urandom_range(0, 1) == 1) do_read("random");
         tick($urandom_range(0, CPB));
      end
      do_read("final");
      tick(10);
      check("events outstanding", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
